// File: rtl/eth_rx_mac_filter.sv
// Ethernet RX destination-address filter with a circular frame buffer.
//
// Bytes from the MAC are written into a DEPTH-entry buffer as they arrive.
// Once the sixth byte (last destination byte) is seen, the frame is either
// committed for output (rd_limit starts tracking wr_ptr) or discarded by
// rewinding wr_ptr to the frame start. Frames that run out of space while
// being forwarded are cut short with a tlast/tuser terminator.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   s_axis_*              MAC RX byte stream (no back-pressure)
//   m_axis_*              filtered byte stream, registered valid/ready
//   local_mac             station address, [47:40] is first on the wire
//   promiscuous,
//   accept_broadcast,
//   accept_multicast      filter controls, sampled on the decision byte
//   stat_frame_pass,
//   stat_frame_drop,
//   stat_overflow         one-cycle event pulses
module eth_rx_mac_filter #(
  parameter int unsigned DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic [47:0] local_mac,
  input  logic        promiscuous,
  input  logic        accept_broadcast,
  input  logic        accept_multicast,
  output logic        stat_frame_pass,
  output logic        stat_frame_drop,
  output logic        stat_overflow
);
  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;
  localparam ptr_t ONE      = ptr_t'(1);
  // Occupancy at or below this leaves at least two free entries.
  localparam ptr_t USED_MAX = ptr_t'(DEPTH - 3);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, HDR, PASS, DROP} state_t;

  state_t      state, state_d;
  ptr_t        wr_ptr, wr_ptr_d, frame_start, frame_start_d;
  ptr_t        rd_ptr, rd_limit, rd_limit_d, used, wr_inc;
  logic [2:0]  byte_cnt, byte_cnt_d;
  logic [39:0] dest_sr, dest_sr_d;
  logic [47:0] dest;
  logic        accept, space_ok, wr_en;
  logic [9:0]  wr_word;
  logic        pass_d, drop_d, ovf_d;
  logic [9:0]  mem [DEPTH];

  // The beat sitting in the output register still counts as occupied, and one
  // entry is always held back, so the usable depth is DEPTH-1 including the
  // overflow terminator. Pointers are pre-update: a same-cycle read is ignored.
  assign used     = wr_ptr - rd_ptr + ptr_t'(m_axis_tvalid);
  assign space_ok = (used <= USED_MAX);
  assign wr_inc   = wr_ptr + ONE;
  assign dest     = {dest_sr, s_axis_tdata};
  assign accept   = promiscuous || (dest == local_mac) ||
                    (accept_broadcast && (dest == '1)) ||
                    (accept_multicast && dest[40]);

  always_comb begin
    state_d       = state;
    wr_en         = 1'b0;
    wr_word       = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    wr_ptr_d      = wr_ptr;
    frame_start_d = frame_start;
    rd_limit_d    = rd_limit;
    byte_cnt_d    = byte_cnt;
    dest_sr_d     = dest_sr;
    pass_d        = 1'b0;
    drop_d        = 1'b0;
    ovf_d         = 1'b0;
    case (state)
      WAIT_IDLE: if (!s_axis_tvalid) state_d = IDLE;
      IDLE: if (s_axis_tvalid) begin
        if (!space_ok) begin
          ovf_d   = 1'b1;
          drop_d  = 1'b1;
          state_d = s_axis_tlast ? IDLE : DROP;
        end else if (s_axis_tlast) begin
          // One-byte runt: nothing is kept, wr_ptr stays put.
          drop_d = 1'b1;
        end else begin
          wr_en         = 1'b1;
          wr_ptr_d      = wr_inc;
          frame_start_d = wr_ptr;
          byte_cnt_d    = 3'd1;
          dest_sr_d     = {dest_sr[31:0], s_axis_tdata};
          state_d       = HDR;
        end
      end
      HDR: if (s_axis_tvalid) begin
        if (!space_ok) begin
          wr_ptr_d = frame_start;
          ovf_d    = 1'b1;
          drop_d   = 1'b1;
          state_d  = s_axis_tlast ? IDLE : DROP;
        end else if (byte_cnt == 3'd5) begin
          if (accept) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_inc;
            rd_limit_d = wr_inc;
            pass_d     = s_axis_tlast;
            state_d    = s_axis_tlast ? IDLE : PASS;
          end else begin
            wr_ptr_d = frame_start;
            drop_d   = 1'b1;
            state_d  = s_axis_tlast ? IDLE : DROP;
          end
        end else if (s_axis_tlast) begin
          wr_ptr_d = frame_start;
          drop_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_inc;
          byte_cnt_d = byte_cnt + 3'd1;
          dest_sr_d  = {dest_sr[31:0], s_axis_tdata};
        end
      end
      PASS: if (s_axis_tvalid) begin
        wr_en      = 1'b1;
        wr_ptr_d   = wr_inc;
        rd_limit_d = wr_inc;
        if (space_ok) begin
          if (s_axis_tlast) begin
            pass_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          // Last slot: close the frame as errored so the consumer sees an end.
          wr_word = {1'b1, 1'b1, s_axis_tdata};
          ovf_d   = 1'b1;
          state_d = s_axis_tlast ? IDLE : DROP;
        end
      end
      DROP: if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= WAIT_IDLE;
      wr_ptr          <= '0;
      frame_start     <= '0;
      rd_limit        <= '0;
      byte_cnt        <= '0;
      dest_sr         <= '0;
      stat_frame_pass <= 1'b0;
      stat_frame_drop <= 1'b0;
      stat_overflow   <= 1'b0;
    end else begin
      state           <= state_d;
      wr_ptr          <= wr_ptr_d;
      frame_start     <= frame_start_d;
      rd_limit        <= rd_limit_d;
      byte_cnt        <= byte_cnt_d;
      dest_sr         <= dest_sr_d;
      stat_frame_pass <= pass_d;
      stat_frame_drop <= drop_d;
      stat_overflow   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && rst_n) mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  // Output register pops an entry whenever it is empty or being accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (!m_axis_tvalid || m_axis_tready) begin
      if (rd_ptr != rd_limit) begin
        {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem[rd_ptr[AW-1:0]];
        rd_ptr        <= rd_ptr + ONE;
        m_axis_tvalid <= 1'b1;
      end else begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Self-checking bench for eth_rx_mac_filter (DEPTH=64 instance).
module tb_eth_rx_mac_filter;
  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [47:0] local_mac = 48'h02_00_00_00_00_01;
  logic        promiscuous = 1'b0;
  logic        accept_broadcast = 1'b0;
  logic        accept_multicast = 1'b0;
  logic        stat_frame_pass, stat_frame_drop, stat_overflow;

  eth_rx_mac_filter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .local_mac(local_mac),
    .promiscuous(promiscuous), .accept_broadcast(accept_broadcast),
    .accept_multicast(accept_multicast),
    .stat_frame_pass(stat_frame_pass), .stat_frame_drop(stat_frame_drop),
    .stat_overflow(stat_overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned byte6_cyc = 0;
  int unsigned first_cyc = 0;
  bit          first_seen = 1'b0;
  bit          rnd_ready = 1'b0;
  int          n_pass = 0, n_drop = 0, n_ovf = 0;
  int          exp_pass = 0, exp_drop = 0, exp_ovf = 0;
  logic [9:0]  rx_q[$];
  logic [9:0]  exp_q[$];
  logic [7:0]  frm[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready)
        rx_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      if (m_axis_tvalid && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (stat_frame_pass) n_pass++;
      if (stat_frame_drop) n_drop++;
      if (stat_overflow)   n_ovf++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) m_axis_tready = ($urandom_range(3) != 0);
  endtask

  task automatic build_frame(input logic [47:0] dest, input int len);
    frm.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6) frm.push_back(dest[47-8*i -: 8]);
      else       frm.push_back(8'($urandom));
    end
  endtask

  task automatic send_frame(input bit bad, input bit gaps);
    for (int i = 0; i < frm.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(4) == 0) begin
          s_axis_tvalid = 1'b0;
          step();
        end
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frm[i];
      s_axis_tlast  = (i == frm.size() - 1);
      s_axis_tuser  = bad && (i == frm.size() - 1);
      if (i == 5) byte6_cyc = cyc;
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  // Address filter decision derived directly from the destination bytes.
  function automatic bit model_accepts();
    bit is_local = 1'b1;
    bit is_bcast = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (frm[i] != local_mac[47-8*i -: 8]) is_local = 1'b0;
      if (frm[i] != 8'hFF) is_bcast = 1'b0;
    end
    return promiscuous || is_local || (accept_broadcast && is_bcast) ||
           (accept_multicast && frm[0][0]);
  endfunction

  task automatic expect_frame(input bit bad);
    if (frm.size() >= 6 && model_accepts()) begin
      for (int i = 0; i < frm.size(); i++) begin
        logic last;
        last = (i == frm.size() - 1);
        exp_q.push_back({bad && last, last, frm[i]});
      end
      exp_pass++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic drain_check(input string tag);
    for (int k = 0; k < 1000; k++) begin
      if (rx_q.size() >= exp_q.size()) break;
      step();
    end
    repeat (8) step();
    chk({tag, " beats"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s beat%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic stats_check(input string tag);
    chk({tag, " pass_cnt"}, 64'(n_pass), 64'(exp_pass));
    chk({tag, " drop_cnt"}, 64'(n_drop), 64'(exp_drop));
    chk({tag, " ovf_cnt"},  64'(n_ovf),  64'(exp_ovf));
    n_pass = 0; n_drop = 0; n_ovf = 0;
    exp_pass = 0; exp_drop = 0; exp_ovf = 0;
  endtask

  initial begin
    logic [47:0] d;
    logic [63:0] r64;
    int          len;
    bit          bad;

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst tlast",  64'(m_axis_tlast),  64'd0);
    chk("rst tuser",  64'(m_axis_tuser),  64'd0);
    chk("rst tdata",  64'(m_axis_tdata),  64'd0);
    chk("rst pass",   64'(stat_frame_pass), 64'd0);
    chk("rst drop",   64'(stat_frame_drop), 64'd0);
    chk("rst ovf",    64'(stat_overflow),   64'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // Matching 64-byte frame, latency from byte 6
    build_frame(48'h02_00_00_00_00_01, 64);
    first_seen = 1'b0;
    expect_frame(1'b0);
    send_frame(1'b0, 1'b0);
    drain_check("basic");
    chk("basic first_seen", 64'(first_seen), 64'd1);
    chk("basic latency", 64'(first_cyc - byte6_cyc), 64'd2);
    stats_check("basic");

    // Foreign unicast dropped, next matching frame intact
    build_frame(48'h02_00_00_00_00_02, 64);
    expect_frame(1'b0);
    send_frame(1'b0, 1'b0);
    drain_check("mismatch");
    build_frame(48'h02_00_00_00_00_01, 70);
    expect_frame(1'b0);
    send_frame(1'b0, 1'b0);
    drain_check("after_mismatch");
    stats_check("mismatch");

    // Broadcast off then on; multicast on then off
    build_frame('1, 32);
    expect_frame(1'b0);
    send_frame(1'b0, 1'b0);
    drain_check("bcast_off");
    accept_broadcast = 1'b1;
    build_frame('1, 32);
    expect_frame(1'b0);
    send_frame(1'b0, 1'b0);
    drain_check("bcast_on");
    accept_broadcast = 1'b0;
    accept_multicast = 1'b1;
    build_frame(48'h01_00_5E_01_02_03, 40);
    expect_frame(1'b0);
    send_frame(1'b0, 1'b0);
    drain_check("mcast_on");
    accept_multicast = 1'b0;
    build_frame(48'h01_00_5E_01_02_03, 40);
    expect_frame(1'b0);
    send_frame(1'b0, 1'b0);
    drain_check("mcast_off");
    stats_check("filters");

    // Runts and the shortest frame that reaches a decision
    for (int l = 4; l <= 6; l++) begin
      build_frame(48'h02_00_00_00_00_01, l);
      expect_frame(1'b0);
      send_frame(1'b0, 1'b0);
      drain_check($sformatf("len%0d", l));
    end
    stats_check("runts");

    // Errored frame forwarded as-is; promiscuous unicast
    build_frame(48'h02_00_00_00_00_01, 20);
    expect_frame(1'b1);
    send_frame(1'b1, 1'b0);
    drain_check("bad_fwd");
    promiscuous = 1'b1;
    build_frame(48'h0A_BB_CC_DD_EE_FF, 25);
    expect_frame(1'b0);
    send_frame(1'b0, 1'b0);
    drain_check("promisc");
    promiscuous = 1'b0;
    stats_check("misc");

    // Overflow with the sink stalled: 62 data beats plus terminator
    m_axis_tready = 1'b0;
    build_frame(48'h02_00_00_00_00_01, 100);
    send_frame(1'b0, 1'b0);
    repeat (6) step();
    chk("ovf stalled beats", 64'(rx_q.size()), 64'd0);
    chk("ovf hold valid", 64'(m_axis_tvalid), 64'd1);
    chk("ovf hold data", 64'(m_axis_tdata), 64'(frm[0]));
    for (int i = 0; i < 62; i++) exp_q.push_back({2'b00, frm[i]});
    exp_q.push_back({2'b11, frm[62]});
    exp_ovf = 1;
    m_axis_tready = 1'b1;
    drain_check("overflow");
    stats_check("overflow");
    build_frame(48'h02_00_00_00_00_01, 30);
    expect_frame(1'b0);
    send_frame(1'b0, 1'b0);
    drain_check("post_ovf");
    stats_check("post_ovf");

    // Reset pulse during byte 20 of a frame
    build_frame(48'h02_00_00_00_00_01, 64);
    for (int i = 0; i < 64; i++) begin
      if (i == 20) begin
        chk("mid_rst tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst pass",   64'(stat_frame_pass), 64'd0);
        rx_q.delete();
        n_pass = 0; n_drop = 0; n_ovf = 0;
        rst_n = 1'b1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frm[i];
      s_axis_tlast  = (i == 63);
      s_axis_tuser  = 1'b0;
      if (i == 19) rst_n = 1'b0;
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drain_check("mid_rst");
    stats_check("mid_rst");
    repeat (4) step();
    build_frame(48'h02_00_00_00_00_01, 64);
    expect_frame(1'b0);
    send_frame(1'b0, 1'b0);
    drain_check("post_rst");
    stats_check("post_rst");

    // Randomized traffic against the reference model
    r64 = {$urandom, $urandom};
    local_mac = r64[47:0];
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      promiscuous      = ($urandom_range(5) == 0);
      accept_broadcast = 1'($urandom_range(1));
      accept_multicast = 1'($urandom_range(1));
      case ($urandom_range(4))
        0: d = local_mac;
        1: d = '1;
        2: d = {24'h01_00_5E, 24'($urandom)};
        3: begin
          r64 = {$urandom, $urandom};
          d = r64[47:0];
          d[40] = 1'b0;
        end
        default: begin
          d = local_mac;
          d[$urandom_range(47)] ^= 1'b1;
        end
      endcase
      len = ($urandom_range(4) == 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(8, 60));
      bad = ($urandom_range(7) == 0);
      build_frame(d, len);
      expect_frame(bad);
      send_frame(bad, 1'b1);
      drain_check($sformatf("rnd%0d", f));
    end
    rnd_ready = 1'b0;
    m_axis_tready = 1'b1;
    stats_check("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_rx_mac_filter.md
ETH_RX_MAC_FILTER -- requirements
Module: eth_rx_mac_filter

Interface
REQ-001 Parameter DEPTH, default 2048: byte-buffer entries; SHALL be a power of 2, >= 64.
REQ-002 clk  input  1  single clock; every flop SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 s_axis_tdata/tvalid/tlast/tuser  input  8/1/1/1  MAC RX byte stream; no tready, never stalled; tuser=1 on tlast marks bad frame.
REQ-005 m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  filtered stream to RX FIFO.
REQ-006 local_mac  input  48  station address; local_mac[47:40] is the first destination byte on the wire.
REQ-007 promiscuous, accept_broadcast, accept_multicast  input  1 each  filter controls, sampled at the decision cycle.
REQ-008 stat_frame_pass, stat_frame_drop, stat_overflow  output  1 each  one-cycle event pulses.

Function
REQ-009 Buffer: circular, DEPTH x 10 bits (data, tlast, tuser); pointers wr_ptr, frame_start, rd_ptr, rd_limit, each log2(DEPTH)+1 bits, modulo wrap.
REQ-010 States: WAIT_IDLE, IDLE, HDR, PASS, DROP.
REQ-011 WAIT_IDLE: discard input; go IDLE after the first cycle with s_axis_tvalid=0.
REQ-012 IDLE: on valid byte, write it, byte_cnt=1, frame_start=wr_ptr, go HDR.
REQ-013 HDR: write each valid byte, increment byte_cnt; the byte with byte_cnt=5 is the decision byte.
REQ-014 Pass test at decision: promiscuous, or dest==local_mac, or (accept_broadcast and dest==48'hFFFFFFFFFFFF), or (accept_multicast and dest bit 40 (first byte, LSB)=1).
REQ-015 Pass: rd_limit follows wr_ptr from next cycle; go PASS (or IDLE if decision byte has tlast).
REQ-016 Fail: wr_ptr rewinds to frame_start; stat_frame_drop=1; go DROP (or IDLE if tlast).
REQ-017 Runt (tlast while byte_cnt<5): rewind to frame_start, stat_frame_drop=1, go IDLE.
REQ-018 PASS: write each byte, rd_limit=wr_ptr+1 each write; on tlast, stat_frame_pass=1, go IDLE; tuser forwarded unchanged.
REQ-019 DROP: discard bytes; go IDLE on tlast.
REQ-020 Space rule: normal write only if free entries >= 2; the last slot is reserved for a terminator.
REQ-021 Overflow in PASS (free==1): write incoming data with tlast=1, tuser=1 into the reserved slot; stat_overflow=1; go DROP (IDLE if input tlast).
REQ-022 Overflow in HDR/IDLE: rewind to frame_start, stat_overflow=1 and stat_frame_drop=1; go DROP (IDLE if tlast).
REQ-023 Output: registered; m_axis_tvalid=1 while an entry in [rd_ptr, rd_limit) is loaded; standard valid/ready, data held stable while tvalid and not tready.
REQ-024 Latency: first byte of a passed frame on m_axis 2 cycles after the decision byte's input cycle; 1 byte/cycle throughput when tready=1.
REQ-025 Simultaneous read and write in same cycle SHALL be supported; free count uses pre-update pointers conservatively (never overwrites unread data).
REQ-026 Frames of a dropped decision SHALL never emit any m_axis beat.

Reset
REQ-027 rst_n=0 at clock edge: all pointers 0, state WAIT_IDLE, m_axis_tvalid=0, tlast=0, tuser=0, tdata=0, all stat pulses 0.
REQ-028 Reset mid-frame: buffered and in-flight data discarded; input discarded until tvalid low (REQ-011).
REQ-029 Buffer RAM contents SHALL NOT require reset.

Verification
REQ-030 local_mac=02:00:00:00:00:01, 64-byte frame to that address, tready=1 -> 64 identical beats, tlast on beat 64, tuser=0, one stat_frame_pass, first beat 2 cycles after byte 6.
REQ-031 Frame to 02:00:00:00:00:02, promiscuous=0 -> no m_axis beats, one stat_frame_drop; following matching frame passes intact.
REQ-032 Broadcast frame with accept_broadcast=0 then 1 -> dropped then passed; multicast 01:00:5E:.. with accept_multicast=1 -> passed.
REQ-033 4-byte frame with tlast -> no output, stat_frame_drop=1; wr_ptr back to pre-frame value.
REQ-034 DEPTH=64, tready=0, 100-byte matching frame -> 63 stored entries, entry 63 tlast=1 tuser=1, stat_overflow=1; releasing tready drains exactly 63 beats.
REQ-035 rst_n low for 1 cycle at byte 20 of a frame -> no further output of that frame; next frame after idle gap passes.
